// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: generates stall, flush and bubble controls for a 5-stage core and
// sequences multi-cycle data-memory waits and multi-cycle fetch flushes after a redirect.
module hazard_sequencer #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy_in,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             redirect_valid,
    input  logic             mem_req,
    input  logic             mem_done,
    output logic             pc_sel,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wide enough to hold FLUSH_CYCLES-1; at least one bit so the FLUSH_CYCLES=1 build stays legal.
    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FlushReload = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic mem_wait;

    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        // Wait is only entered from RUN; once waiting, only mem_done releases it.
        mem_wait = ((state_q == StRun) && mem_req && !mem_done) ||
                   ((state_q == StMemWait) && !mem_done);
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        pc_sel        = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;

        if (!rdy_in) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (!rst_n) begin
            state_d     = StRun;
            flush_cnt_d = '0;
        end else if (mem_wait) begin
            // A redirect arriving now is deferred: MEM is frozen and re-presents it later.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = StMemWait;
        end else if (redirect_valid) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = StFlush;
                flush_cnt_d = FlushReload;
            end else begin
                state_d     = StRun;
            end
        end else if (state_q == StFlush) begin
            if_id_flush = 1'b1;
            flush_cnt_d = flush_cnt_q - FCW'(1);
            if (flush_cnt_q == FCW'(1)) begin
                state_d = StRun;
            end
        end else begin
            // RUN, or the release cycle of a memory wait.
            state_d = StRun;
            if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (rdy_in && pc_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StRun;
            flush_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign state_o      = rst_n ? state_q : StRun;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a FLUSH_CYCLES=3 instance checked cycle by cycle, plus a
// FLUSH_CYCLES=1 / CNT_W=2 instance for the single-cycle redirect and counter saturation.
module tb_hazard_sequencer;

    localparam int unsigned REG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rdy_in;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_valid;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             redirect_valid;
    logic             mem_req;
    logic             mem_done;

    logic        pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall;
    logic        mem_wb_bubble;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles;

    logic        b_pc_sel, b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush;
    logic        b_ex_mem_stall, b_mem_wb_bubble;
    logic [1:0]  b_state_o;
    logic [1:0]  b_stall_cycles;

    // {pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble}
    logic [6:0] outs, b_outs;
    assign outs   = {pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall,
                     mem_wb_bubble};
    assign b_outs = {b_pc_sel, b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush,
                     b_ex_mem_stall, b_mem_wb_bubble};

    localparam logic [6:0] ONone  = 7'b0000000;
    localparam logic [6:0] OLoad  = 7'b0110100;
    localparam logic [6:0] OMem   = 7'b0110011;
    localparam logic [6:0] ORedir = 7'b1001100;
    localparam logic [6:0] OFlush = 7'b0001000;
    localparam logic [6:0] OFrz   = 7'b0110010;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.REG_W(REG_W), .FLUSH_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .redirect_valid(redirect_valid), .mem_req(mem_req), .mem_done(mem_done),
        .pc_sel(pc_sel), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .state_o(state_o), .stall_cycles(stall_cycles)
    );

    hazard_sequencer #(.REG_W(REG_W), .FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .redirect_valid(redirect_valid), .mem_req(mem_req), .mem_done(mem_done),
        .pc_sel(b_pc_sel), .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
        .ex_mem_stall(b_ex_mem_stall), .mem_wb_bubble(b_mem_wb_bubble), .state_o(b_state_o),
        .stall_cycles(b_stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy_in = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
        redirect_valid = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_load_use(input logic [REG_W-1:0] rd);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
        id_valid = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    endtask

    // Applies current inputs, waits 1 time unit, compares outputs and state of the main DUT.
    task automatic chk(input string name, input logic [6:0] exp_o, input logic [1:0] exp_s);
        #1;
        vectors++;
        if (outs !== exp_o || state_o !== exp_s) begin
            miscompares++;
            $display("FAIL %s: outs=%b state=%0d, expected outs=%b state=%0d",
                     name, outs, state_o, exp_o, exp_s);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        mem_req = 1'b1;
        redirect_valid = 1'b1;
        tick();
        chk("reset_gated", ONone, 2'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        chk("reset_idle", ONone, 2'd0);
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: stall_cycles=%0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        chk("lu_hit", OLoad, 2'd0);
        tick();
        ex_mem_read = 1'b0;
        chk("lu_clear", ONone, 2'd0);
        vectors++;
        if (stall_cycles !== 32'd1 || b_stall_cycles !== 2'd1) begin
            miscompares++;
            $display("FAIL lu_cnt: stall_cycles=%0d/%0d expected 1/1", stall_cycles,
                     b_stall_cycles);
        end
        set_load_use(5'd0);
        id_rs2 = 5'd0;
        chk("lu_rd0", ONone, 2'd0);
        set_load_use(5'd7);
        id_rs1 = 5'd7;
        chk("lu_rs1_unused", ONone, 2'd0);
        id_use_rs1 = 1'b1;
        chk("lu_rs1_hit", OLoad, 2'd0);
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1;
        chk("mw_enter", OMem, 2'd0);
        tick();
        redirect_valid = 1'b1;
        set_load_use(5'd5);
        chk("mw_wait1_ign", OMem, 2'd1);
        tick();
        clear_inputs();
        mem_req = 1'b1;
        chk("mw_wait2", OMem, 2'd1);
        tick();
        mem_done = 1'b1;
        chk("mw_release", ONone, 2'd1);
        tick();
        clear_inputs();
        chk("mw_run", ONone, 2'd0);
        vectors++;
        if (stall_cycles !== 32'd3) begin
            miscompares++;
            $display("FAIL mw_cnt: stall_cycles=%0d expected 3", stall_cycles);
        end
        mem_req = 1'b1;
        mem_done = 1'b1;
        chk("mw_single", ONone, 2'd0);
        clear_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_valid = 1'b1;
        chk("rd_pulse", ORedir, 2'd0);
        tick();
        redirect_valid = 1'b0;
        chk("rd_flush1", OFlush, 2'd2);
        vectors++;
        if (b_state_o !== 2'd0 || b_outs !== ONone) begin
            miscompares++;
            $display("FAIL rd_fc1: state=%0d outs=%b expected 0/%b", b_state_o, b_outs, ONone);
        end
        tick();
        chk("rd_flush2", OFlush, 2'd2);
        tick();
        chk("rd_done", ONone, 2'd0);
        redirect_valid = 1'b1;
        chk("rd2_pulse", ORedir, 2'd0);
        tick();
        chk("rd2_again", ORedir, 2'd2);
        tick();
        redirect_valid = 1'b0;
        set_load_use(5'd5);
        chk("rd2_lu_supp", OFlush, 2'd2);
        tick();
        clear_inputs();
        chk("rd2_flush3", OFlush, 2'd2);
        tick();
        chk("rd2_done", ONone, 2'd0);
    endtask

    task automatic test_conflicts();
        do_reset();
        set_load_use(5'd5);
        redirect_valid = 1'b1;
        chk("cf_redir_lu", ORedir, 2'd0);
        clear_inputs();
        tick();
        tick();
        tick();
        mem_req = 1'b1;
        redirect_valid = 1'b1;
        chk("cf_mw_wins", OMem, 2'd0);
        tick();
        mem_done = 1'b1;
        chk("cf_release_redir", ORedir, 2'd1);
        tick();
        clear_inputs();
        chk("cf_after_release", OFlush, 2'd2);

        do_reset();
        mem_req = 1'b1;
        tick();
        rdy_in = 1'b0;
        mem_done = 1'b1;
        chk("cf_frz1", OFrz, 2'd1);
        tick();
        chk("cf_frz2", OFrz, 2'd1);
        tick();
        rdy_in = 1'b1;
        chk("cf_unfrz", ONone, 2'd1);
        tick();
        clear_inputs();
        chk("cf_unfrz_run", ONone, 2'd0);
        vectors++;
        if (stall_cycles !== 32'd1) begin
            miscompares++;
            $display("FAIL cf_frz_cnt: stall_cycles=%0d expected 1", stall_cycles);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_load_use(5'd5);
        tick();
        clear_inputs();
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("rm_in_flush", OFlush, 2'd2);
        rst_n = 1'b0;
        chk("rm_gated", ONone, 2'd0);
        tick();
        rst_n = 1'b1;
        chk("rm_after", ONone, 2'd0);
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL rm_cnt: stall_cycles=%0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        mem_done = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (stall_cycles !== 32'd5 || b_stall_cycles !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_cnt: stall_cycles=%0d/%0d expected 5/3", stall_cycles,
                     b_stall_cycles);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_conflicts();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central pipeline control for the 5-stage core. It freezes, bubbles and flushes the IF/ID/EX/MEM/WB stage registers and selects the redirect PC.
- Inputs: decoded source registers in ID, the in-flight instruction in EX (including its decoded mem/wb class), the redirect resolved in MEM, and the data-memory handshake.
- A small FSM sequences multi-cycle memory waits and multi-cycle fetch flushes.

Parameters:
REG_W, 5, register index width
FLUSH_CYCLES, 1, cycles if_id_flush stays high per redirect (>=1; fetch latency)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rdy_in  in  1  global ready; low = freeze everything
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_W  ID source 1
id_rs2  in  REG_W  ID source 2
id_use_rs1  in  1  ID reads rs1
id_use_rs2  in  1  ID reads rs2
ex_valid  in  1  EX holds a real instruction
ex_rd  in  REG_W  EX destination
ex_mem_read  in  1  EX is a load (mem stage state READ)
redirect_valid  in  1  MEM resolved taken branch/jump
mem_req  in  1  MEM stage issues data access
mem_done  in  1  data access complete
pc_sel  out  1  1 = PC takes redirect target
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to bubble
id_ex_flush  out  1  insert bubble into ID/EX
ex_mem_stall  out  1  hold ID/EX and EX/MEM
mem_wb_bubble  out  1  insert bubble into MEM/WB
state_o  out  2  FSM state (debug)
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Outputs are combinational from state and inputs. State, flush counter and stall_cycles update on posedge clk.
- Reset (rst_n low at posedge): state=RUN, flush_cnt=0, stall_cycles=0. While rst_n is low, all 1-bit outputs are forced to 0 and state_o=0.
- States: RUN=0, MEM_WAIT=1, FLUSH=2.
- rdy_in=0 (overrides all): pc_stall, if_id_stall and ex_mem_stall are 1; flushes, bubbles and pc_sel are 0. State, counters and stall_cycles hold.
- MEM_WAIT condition: in RUN, mem_req=1 and mem_done=0.
  - Same cycle: pc_stall, if_id_stall, ex_mem_stall and mem_wb_bubble are 1. Next state is MEM_WAIT.
  - mem_req=1 with mem_done=1 in the same cycle is single-cycle: no stall.
- MEM_WAIT:
  - mem_done=0: same outputs as above; redirect_valid and load-use are ignored (MEM is frozen, so the redirect is re-presented later).
  - mem_done=1: stall outputs drop that cycle and the cycle is evaluated as RUN (redirect/load-use apply). Next state is RUN, or FLUSH per the redirect rule.
- Redirect (evaluated in RUN, in FLUSH, and on the MEM_WAIT release cycle): pc_sel=1, if_id_flush=1, id_ex_flush=1, no stalls.
  - FLUSH_CYCLES=1: stay in RUN.
  - FLUSH_CYCLES>1: next state is FLUSH with flush_cnt=FLUSH_CYCLES-1.
- FLUSH:
  - if_id_flush=1 each cycle and flush_cnt decrements.
  - flush_cnt==1 -> RUN next.
  - A new redirect in FLUSH reloads flush_cnt=FLUSH_CYCLES-1 and asserts pc_sel.
  - Load-use is suppressed in FLUSH.
- Load-use hazard (RUN only), detected when all hold:
  - id_valid & ex_valid & ex_mem_read & ex_rd!=0, and
  - (id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly that cycle. The hazard clears naturally as the load advances.
- Priority: rdy_in low > reset gating > MEM_WAIT stall > redirect > load-use.
  - A redirect wins over a simultaneous load-use: no stall, flush only.
  - A MEM_WAIT entry in the same cycle as a redirect: the stall wins and the redirect is deferred.
- stall_cycles increments when pc_stall=1 and rdy_in=1, and saturates at all-ones.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then all inputs 0 -> all 1-bit outputs 0, state_o=0, stall_cycles=0.
- Load-use: ex_mem_read=1, ex_rd=5, ex_valid=1; ID id_rs2=5, id_use_rs2=1, id_valid=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Memory wait: mem_req=1, mem_done low for 3 cycles then high -> state_o=1 for 3 cycles with all four stall/bubble outputs 1; released on the done cycle; stall_cycles=3.
- Redirect with FLUSH_CYCLES=3: redirect_valid pulse -> pc_sel=1 for 1 cycle, if_id_flush=1 for 3 cycles, state_o=2 for 2 cycles. A second redirect in the 2nd cycle extends if_id_flush to 4 cycles total.
- Conflicts:
  - redirect_valid together with a load-use match -> pc_sel=1, if_id_flush=id_ex_flush=1, pc_stall=0.
  - rdy_in=0 mid-MEM_WAIT with mem_done=1 -> state stays 1 until rdy_in returns.
- Reset mid-operation: rst_n=0 during FLUSH with flush_cnt=2 -> next cycle state_o=0, if_id_flush=0, stall_cycles=0.
